// File: rtl/pacman_mover.sv
// Pac-Man position, facing and mouth animation, advanced once per video frame.
// Also derives sprite-relative pixel offsets for the downstream bitmap stage.
module pacman_mover #(
  parameter int START_X      = 304,
  parameter int START_Y      = 232,
  parameter int SPEED        = 1,
  parameter int MOVE_DIV     = 2,
  parameter int MOUTH_FRAMES = 8,
  parameter int SCREEN_W     = 640,
  parameter int SPRITE       = 16
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  input  logic        start_of_frame,
  input  logic        enable,
  input  logic        respawn,
  input  logic        dir_valid,
  input  logic [1:0]  dir_req,
  input  logic [3:0]  blocked,
  output logic [10:0] offset_x,
  output logic [10:0] offset_y,
  output logic        in_container,
  output logic [1:0]  orientation,
  output logic        close_mouth,
  output logic [10:0] top_left_x,
  output logic [10:0] top_left_y,
  output logic        moving
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic [1:0]  DIR_UP    = 2'b00;
  localparam logic [1:0]  DIR_DOWN  = 2'b01;
  localparam logic [1:0]  DIR_LEFT  = 2'b10;
  localparam logic [1:0]  DIR_RIGHT = 2'b11;

  localparam logic [10:0] START_X11  = 11'(START_X);
  localparam logic [10:0] START_Y11  = 11'(START_Y);
  localparam logic [11:0] SPEED12    = 12'(SPEED);
  localparam logic [11:0] SPRITE12   = 12'(SPRITE);
  localparam logic [11:0] WRAP_X12   = 12'(SCREEN_W - SPRITE);
  localparam logic [3:0]  FRAME_LAST = 4'(MOVE_DIV - 1);
  localparam logic [5:0]  MOUTH_LAST = 6'(MOUTH_FRAMES - 1);

  state_t      state_q, state_d;
  logic [10:0] tlx_q, tlx_d;
  logic [10:0] tly_q, tly_d;
  logic [1:0]  orient_q, orient_d;
  logic [1:0]  pending_q, pending_d;
  logic        close_q, close_d;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [5:0]  mouth_cnt_q, mouth_cnt_d;

  // X step with tunnel wrap at both screen edges.
  function automatic logic [10:0] step_x(input logic [10:0] x, input logic [1:0] dir);
    logic [11:0] x12;
    logic [11:0] nx;
    x12 = {1'b0, x};
    nx  = x12;
    if (dir == DIR_LEFT) begin
      nx = (x12 < SPEED12) ? WRAP_X12 : x12 - SPEED12;
    end else if (dir == DIR_RIGHT) begin
      nx = x12 + SPEED12;
      if (nx > WRAP_X12) nx = 12'd0;
    end
    return nx[10:0];
  endfunction

  // Y step; walls keep Y in range so there is no wrap.
  function automatic logic [10:0] step_y(input logic [10:0] y, input logic [1:0] dir);
    logic [10:0] ny;
    ny = y;
    if (dir == DIR_UP)        ny = y - SPEED12[10:0];
    else if (dir == DIR_DOWN) ny = y + SPEED12[10:0];
    return ny;
  endfunction

  // Next-state logic: direction latch, frame divider, motion FSM and mouth phase.
  always_comb begin
    logic       tick;
    logic [1:0] new_orient;
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    tlx_d       = tlx_q;
    tly_d       = tly_q;
    orient_d    = orient_q;
    close_d     = close_q;
    frame_cnt_d = frame_cnt_q;
    mouth_cnt_d = mouth_cnt_q;
    pending_d   = dir_valid ? dir_req : pending_q;
    tick        = (frame_cnt_q == FRAME_LAST);
    new_orient  = blocked[pending_q] ? orient_q : pending_q;

    if (respawn) begin
      state_d     = IDLE;
      tlx_d       = START_X11;
      tly_d       = START_Y11;
      orient_d    = DIR_RIGHT;
      pending_d   = DIR_RIGHT;
      close_d     = 1'b0;
      frame_cnt_d = '0;
      mouth_cnt_d = '0;
    end else if (start_of_frame) begin
      case (state_q)
        IDLE: begin
          frame_cnt_d = '0;
          if (enable) state_d = RUN;
        end
        RUN, STOPPED: begin
          if (!enable) begin
            state_d     = IDLE;
            frame_cnt_d = '0;
            mouth_cnt_d = '0;
            close_d     = 1'b0;
          end else begin
            frame_cnt_d = tick ? 4'd0 : frame_cnt_q + 4'd1;
            if (tick && state_q == RUN) begin
              orient_d = new_orient;
              if (!blocked[new_orient]) begin
                tlx_d = step_x(tlx_q, new_orient);
                tly_d = step_y(tly_q, new_orient);
                if (mouth_cnt_q == MOUTH_LAST) begin
                  mouth_cnt_d = '0;
                  close_d     = ~close_q;
                end else begin
                  mouth_cnt_d = mouth_cnt_q + 6'd1;
                end
              end else begin
                state_d     = STOPPED;
                mouth_cnt_d = '0;
                close_d     = 1'b0;
              end
            end else if (tick && !blocked[pending_q]) begin
              state_d  = RUN;
              orient_d = pending_q;
              tlx_d    = step_x(tlx_q, pending_q);
              tly_d    = step_y(tly_q, pending_q);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      tlx_q       <= START_X11;
      tly_q       <= START_Y11;
      orient_q    <= DIR_RIGHT;
      pending_q   <= DIR_RIGHT;
      close_q     <= 1'b0;
      frame_cnt_q <= '0;
      mouth_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q     <= state_d;
      tlx_q       <= tlx_d;
      tly_q       <= tly_d;
      orient_q    <= orient_d;
      pending_q   <= pending_d;
      close_q     <= close_d;
      frame_cnt_q <= frame_cnt_d;
      mouth_cnt_q <= mouth_cnt_d;
    end
  end

  // Pixel-to-sprite geometry; 12-bit compares so tl+SPRITE cannot overflow.
  always_comb begin
    logic [11:0] px12, py12, tlx12, tly12;
    px12  = {1'b0, pixel_x};
    py12  = {1'b0, pixel_y};
    tlx12 = {1'b0, tlx_q};
    tly12 = {1'b0, tly_q};
    in_container = (px12 >= tlx12) && (px12 < tlx12 + SPRITE12) &&
                   (py12 >= tly12) && (py12 < tly12 + SPRITE12);
    offset_x = in_container ? pixel_x - tlx_q : 11'd0;
    offset_y = in_container ? pixel_y - tly_q : 11'd0;
  end

  assign orientation = orient_q;
  assign close_mouth = close_q;
  assign top_left_x  = tlx_q;
  assign top_left_y  = tly_q;
  assign moving      = (state_q == RUN);

endmodule
